// File: rtl/ofm_relu_pool_if.sv
`default_nettype none
// ============================================================================
// Module   : ofm_relu_pool_if
// Purpose  : OFM sample stream in, pooled byte stream and status out.
// Revision : 1.0 - initial release
// ============================================================================
interface ofm_relu_pool_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_end;
    logic                  out_valid;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_last;
    logic                  pool_done;
    logic                  err;

    modport master (
        output in_valid, in_data, in_end,
        input  out_valid, out_data, out_last, pool_done, err
    );

    modport slave (
        input  in_valid, in_data, in_end,
        output out_valid, out_data, out_last, pool_done, err
    );
endinterface
`default_nettype wire

// File: rtl/ofm_relu_pool.sv
`default_nettype none
// ============================================================================
// Module   : ofm_relu_pool
// Purpose  : ReLU + shift requantization + 2x2/2 max pooling of the conv-core
//            OFM stream, one half-row line buffer. OFM_RELU_EN selects
//            ReLU/unsigned output; undefined gives signed saturation.
// Revision : 1.0 - initial release
// ============================================================================
module ofm_relu_pool #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter int OFM_SIZE   = 16,
    parameter int CO         = 3,
    parameter int SHIFT      = 8
) (
    input  logic             clk1,
    input  logic             rst,
    ofm_relu_pool_if.slave   bus
);
    localparam int c_CW   = $clog2(OFM_SIZE);
    localparam int c_HALF = OFM_SIZE / 2;
    localparam int c_HW   = (OFM_SIZE > 2) ? $clog2(c_HALF) : 1;
    localparam int c_KW   = (CO > 1) ? $clog2(CO) : 1;
    localparam logic [c_CW-1:0] c_LAST    = c_CW'(OFM_SIZE - 1);
    localparam logic [c_KW-1:0] c_CH_LAST = c_KW'(CO - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ACTIVE   = 2'd1;
    localparam logic [1:0] S_WAIT_END = 2'd2;

    logic [1:0]           r_state;
    logic [c_CW-1:0]      r_col;
    logic [c_CW-1:0]      r_row;
    logic [c_KW-1:0]      r_ch;
    logic [OUT_WIDTH-1:0] r_pair;
    logic                 r_end_pend;
    logic                 r_out_valid;
    logic [OUT_WIDTH-1:0] r_out_data;
    logic                 r_out_last;
    logic                 r_pool_done;
    logic                 r_err;
    logic [OUT_WIDTH-1:0] r_linebuf [c_HALF];

    logic signed [DATA_WIDTH-1:0] w_shifted;
    logic [OUT_WIDTH-1:0]         w_q;
    logic [OUT_WIDTH-1:0]         w_pmax;
    logic [OUT_WIDTH-1:0]         w_win;
    logic [c_HW-1:0]              w_idx;
    logic                         w_last_smp;
    logic                         w_abort;
    logic                         w_accept;
    logic                         w_lb_we;

    function automatic logic [OUT_WIDTH-1:0] f_max(input logic [OUT_WIDTH-1:0] a,
                                                   input logic [OUT_WIDTH-1:0] b);
`ifdef OFM_RELU_EN
        return (a > b) ? a : b;
`else
        return ($signed(a) > $signed(b)) ? a : b;
`endif
    endfunction

    assign w_shifted = $signed(bus.in_data) >>> SHIFT;

`ifdef OFM_RELU_EN
    localparam logic signed [DATA_WIDTH-1:0] c_QMAX = DATA_WIDTH'((2 ** OUT_WIDTH) - 1);

    // Sign survives the arithmetic shift, so a negative shifted value means negative input.
    always_comb begin
        if (w_shifted[DATA_WIDTH-1])
            w_q = '0;
        else if (w_shifted > c_QMAX)
            w_q = '1;
        else
            w_q = w_shifted[OUT_WIDTH-1:0];
    end
`else
    localparam logic signed [DATA_WIDTH-1:0] c_QMAX = DATA_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [DATA_WIDTH-1:0] c_QMIN = ~c_QMAX;

    always_comb begin
        if (w_shifted > c_QMAX)
            w_q = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        else if (w_shifted < c_QMIN)
            w_q = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        else
            w_q = w_shifted[OUT_WIDTH-1:0];
    end
`endif

    assign w_idx      = c_HW'(r_col >> 1);
    assign w_pmax     = f_max(r_pair, w_q);
    assign w_win      = f_max(r_linebuf[w_idx], w_pmax);
    assign w_last_smp = (r_col == c_LAST) && (r_row == c_LAST) && (r_ch == c_CH_LAST);
    // An end marker riding on the final sample is a clean finish, not an abort.
    assign w_abort    = (r_state == S_ACTIVE) && bus.in_end && !(bus.in_valid && w_last_smp);
    assign w_accept   = bus.in_valid && ((r_state == S_IDLE) ||
                                         ((r_state == S_ACTIVE) && !w_abort));
    assign w_lb_we    = w_accept && !r_row[0] && r_col[0];

    always_ff @(posedge clk1) begin
        if (w_lb_we)
            r_linebuf[w_idx] <= w_pmax;
    end

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_col       <= '0;
            r_row       <= '0;
            r_ch        <= '0;
            r_pair      <= '0;
            r_end_pend  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_pool_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_pool_done <= 1'b0;

            if (w_accept) begin
                if (!r_col[0]) begin
                    r_pair <= w_q;
                end else if (r_row[0]) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_win;
                    r_out_last  <= w_last_smp;
                end

                if (r_col == c_LAST) begin
                    r_col <= '0;
                    if (r_row == c_LAST) begin
                        r_row <= '0;
                        r_ch  <= (r_ch == c_CH_LAST) ? '0 : r_ch + 1'b1;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid)
                        r_state <= S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (w_abort) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_ch    <= '0;
                        r_pair  <= '0;
                    end else if (w_accept && w_last_smp) begin
                        r_state    <= S_WAIT_END;
                        r_end_pend <= bus.in_end;
                    end
                end
                S_WAIT_END: begin
                    if (bus.in_valid)
                        r_err <= 1'b1;
                    if (bus.in_end || r_end_pend) begin
                        r_pool_done <= 1'b1;
                        r_end_pend  <= 1'b0;
                        r_state     <= S_IDLE;
                        r_col       <= '0;
                        r_row       <= '0;
                        r_ch        <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_last  = r_out_last;
    assign bus.pool_done = r_pool_done;
    assign bus.err       = r_err;
endmodule
`default_nettype wire

// File: tb/tb_ofm_relu_pool.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofm_relu_pool
// Purpose  : Directed + randomized frames for ofm_relu_pool against a
//            window-level reference model (honours OFM_RELU_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ofm_relu_pool;
    localparam int DW    = 32;
    localparam int OW    = 8;
    localparam int S     = 4;
    localparam int CO    = 2;
    localparam int SHIFT = 2;
    localparam int H     = S / 2;
    localparam int NTOT  = CO * S * S;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ofm_relu_pool_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus ();

    ofm_relu_pool #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .OFM_SIZE(S), .CO(CO), .SHIFT(SHIFT)
    ) dut (
        .clk1 (clk),
        .rst  (rst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int pd_cnt   = 0;
    int pd_cyc   = -1;
    int end_cyc  = 0;
    int frame [NTOT];
    logic [OW-1:0] got_d [$];
    logic          got_l [$];
    logic [OW-1:0] exp_d [$];
    logic          exp_l [$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid) begin
            got_d.push_back(bus.out_data);
            got_l.push_back(bus.out_last);
        end
        if (bus.pool_done) begin
            pd_cnt++;
            pd_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        assert (got === expv) else begin
            n_errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic int quant(input int x);
        int s;
        s = x >>> SHIFT;
`ifdef OFM_RELU_EN
        if (x < 0) return 0;
        if (s > (2 ** OW) - 1) return (2 ** OW) - 1;
        return s;
`else
        if (s > (2 ** (OW - 1)) - 1) return (2 ** (OW - 1)) - 1;
        if (s < -(2 ** (OW - 1))) return -(2 ** (OW - 1));
        return s;
`endif
    endfunction

    // Expected pooled stream for the first n samples of frame[].
    task automatic build_exp(input int n);
        exp_d.delete();
        exp_l.delete();
        for (int ch = 0; ch < CO; ch++)
            for (int pr = 0; pr < H; pr++)
                for (int pc = 0; pc < H; pc++) begin
                    int base, m;
                    base = ch * S * S;
                    if (base + (2 * pr + 1) * S + 2 * pc + 1 < n) begin
                        m = quant(frame[base + 2 * pr * S + 2 * pc]);
                        for (int k = 1; k < 4; k++) begin
                            int v;
                            v = quant(frame[base + (2 * pr + k / 2) * S + 2 * pc + k % 2]);
                            if (v > m) m = v;
                        end
                        exp_d.push_back(OW'(m));
                        exp_l.push_back(ch == CO - 1 && pr == H - 1 && pc == H - 1);
                    end
                end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_end   = 1'b0;
    endtask

    task automatic drive(input int n, input int gap_max, input bit end_with_last);
        for (int i = 0; i < n; i++) begin
            int g;
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) idle_cycle();
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_data  = frame[i];
            bus.in_end   = end_with_last && (i == n - 1);
            if (end_with_last && (i == n - 1)) end_cyc = cyc;
        end
        idle_cycle();
    endtask

    task automatic send_end(input bit with_valid);
        @(posedge clk); #1;
        bus.in_end   = 1'b1;
        bus.in_valid = with_valid;
        bus.in_data  = 32'h0000_7FFF;
        end_cyc      = cyc;
        idle_cycle();
    endtask

    task automatic compare_outputs(input string tag, input int n);
        build_exp(n);
        check({tag, " count"}, got_d.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++) begin
            if (i < got_d.size()) begin
                check($sformatf("%s data[%0d]", tag, i), got_d[i], exp_d[i]);
                check($sformatf("%s last[%0d]", tag, i), got_l[i], exp_l[i]);
            end
        end
    endtask

    task automatic gen_const(input int v0, input int v1);
        for (int i = 0; i < NTOT; i++) frame[i] = (i < S * S) ? v0 : v1;
    endtask

    task automatic gen_rand();
        for (int i = 0; i < NTOT; i++)
            frame[i] = ($urandom_range(0, 7) == 0) ? int'($urandom)
                                                   : int'($urandom_range(0, 3000)) - 1500;
    endtask

    task automatic run_full(input string tag, input int gap_max, input bit end_with_last,
                            input bit extra_valid, input logic exp_err);
        int pd0;
        got_d.delete();
        got_l.delete();
        pd0 = pd_cnt;
        drive(NTOT, gap_max, end_with_last);
        if (!end_with_last) begin
            if (extra_valid) begin
                @(posedge clk); #1;
                bus.in_valid = 1'b1;
                bus.in_data  = 32'h0001_0000;
                idle_cycle();
            end
            send_end(extra_valid);
        end
        repeat (4) @(negedge clk);
        compare_outputs(tag, NTOT);
        check({tag, " pool_done count"}, pd_cnt - pd0, 1);
        check({tag, " pool_done delay"}, pd_cyc - end_cyc, end_with_last ? 2 : 1);
        check({tag, " err"}, bus.err, exp_err);
    endtask

    initial begin
        int pd0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_end   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset out_valid", bus.out_valid, 0);
        check("reset out_data", bus.out_data, 0);
        check("reset out_last", bus.out_last, 0);
        check("reset pool_done", bus.pool_done, 0);
        check("reset err", bus.err, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle();

        for (int i = 0; i < NTOT; i++) frame[i] = (i + 1) * 4;
        run_full("ramp", 0, 1'b0, 1'b0, 1'b0);

        gen_const(-5, -5);
        run_full("neg5", 0, 1'b0, 1'b0, 1'b0);

        gen_const(32'h0001_0000, 32'h0000_0300);
        run_full("sat", 1, 1'b0, 1'b0, 1'b0);

        gen_const(32'h7FFF_FFFF, 32'h8000_0000);
        run_full("extreme", 0, 1'b0, 1'b0, 1'b0);

        gen_rand();
        run_full("rand_gaps", 3, 1'b0, 1'b0, 1'b0);

        gen_rand();
        run_full("rand_end_last", 0, 1'b1, 1'b0, 1'b0);

        gen_rand();
        run_full("wait_end_valid", 2, 1'b0, 1'b1, 1'b1);

        // Premature end marker after 7 samples.
        gen_rand();
        got_d.delete();
        got_l.delete();
        pd0 = pd_cnt;
        drive(7, 2, 1'b0);
        send_end(1'b0);
        repeat (4) @(negedge clk);
        compare_outputs("abort", 7);
        check("abort pool_done count", pd_cnt - pd0, 0);
        check("abort err", bus.err, 1);

        gen_rand();
        run_full("after_abort", 1, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a frame.
        gen_rand();
        got_d.delete();
        got_l.delete();
        drive(10, 1, 1'b0);
        repeat (2) @(negedge clk);
        compare_outputs("pre_rst", 10);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst out_valid", bus.out_valid, 0);
        check("midrst out_data", bus.out_data, 0);
        check("midrst err", bus.err, 0);
        check("midrst pool_done", bus.pool_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle_cycle();

        gen_rand();
        run_full("after_rst", 2, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
